// File: rtl/csi_pkg.sv
// -----------------------------------------------------------------------------
// csi_pkg
// Shared types and helpers for the CSI extractor magnitude-averaging stage.
//   csi_avg_state_t : control states of csi_mag_averager
//   calc_acc_width  : accumulator width for a given sample width and the
//                     log2 of the number of frames summed
// -----------------------------------------------------------------------------
package csi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } csi_avg_state_t;

   // Summing 2**log2_avg unsigned samples needs log2_avg extra bits.
   function automatic int calc_acc_width(input int data_width, input int log2_avg);
      return data_width + log2_avg;
   endfunction

endpackage

// File: rtl/csi_acc_ram.sv
// -----------------------------------------------------------------------------
// csi_acc_ram
// Simple dual-port accumulator memory, DEPTH x WIDTH, contents not reset.
//   clk_in      : clock
//   i_wr_en     : write strobe
//   i_wr_addr   : write address
//   i_wr_data   : write data
//   i_rd_en     : read strobe; o_rd_data updates on the next edge only when set
//   i_rd_addr   : read address
//   o_rd_data   : registered read data (1-cycle latency, holds when idle)
// -----------------------------------------------------------------------------
module csi_acc_ram #(
   parameter int DEPTH  = 64,
   parameter int WIDTH  = 35,
   parameter int ADDR_W = 6
) (
   input  logic              clk_in,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk_in) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/csi_mag_averager.sv
// -----------------------------------------------------------------------------
// csi_mag_averager
// Accumulates 2**LOG2_AVG frames of NUM_SC magnitudes per subcarrier, then
// streams one averaged frame out on a valid/ready interface.
//   clk_in, rst_in       : clock, synchronous active-high reset
//   mag_in, mag_valid_in : input magnitude stream (no backpressure)
//   sof_in               : marks subcarrier 0, qualified by mag_valid_in
//   avg_out              : averaged magnitude
//   avg_index_out        : subcarrier index of avg_out
//   avg_valid_out        : output beat valid
//   avg_last_out         : beat is subcarrier NUM_SC-1
//   avg_ready_in         : downstream accepts beat
//   busy_out             : accumulating or draining
//   drop_out             : one-cycle pulse per discarded input sample
// Build option: define CSI_AVG_ROUND_EN for round-half-up averaging instead
// of a truncating shift.
// -----------------------------------------------------------------------------
module csi_mag_averager
   import csi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SC     = 64,
   parameter int LOG2_AVG   = 3
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [DATA_WIDTH-1:0]     mag_in,
   input  logic                      mag_valid_in,
   input  logic                      sof_in,
   output logic [DATA_WIDTH-1:0]     avg_out,
   output logic [$clog2(NUM_SC)-1:0] avg_index_out,
   output logic                      avg_valid_out,
   output logic                      avg_last_out,
   input  logic                      avg_ready_in,
   output logic                      busy_out,
   output logic                      drop_out
);

   localparam int ACC_WIDTH = calc_acc_width(DATA_WIDTH, LOG2_AVG);
   localparam int IDX_W     = $clog2(NUM_SC);
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_SC - 1);
   localparam logic [LOG2_AVG-1:0] FRAME_MAX = '1;

   csi_avg_state_t      r_state, w_state_next;
   logic [IDX_W-1:0]    r_sc_idx, w_sc_idx_next;
   logic [LOG2_AVG-1:0] r_frame_cnt, w_frame_next;
   logic                r_drop, w_drop;

   // Drain read issue pointer and the three-deep output pipeline:
   // A = read in flight (RAM output register), O = output beat, S = skid.
   logic [IDX_W-1:0]      r_rd_ptr, w_rd_ptr_next;
   logic                  r_issue_done, w_issue_done_next;
   logic                  w_a_issue;
   logic                  r_a_valid;
   logic [IDX_W-1:0]      r_a_idx;
   logic                  r_o_valid, r_s_valid;
   logic [DATA_WIDTH-1:0] r_o_data, r_s_data;
   logic [IDX_W-1:0]      r_o_idx, r_s_idx;

   logic                  w_wr_en, w_clr, w_rd_en;
   logic [IDX_W-1:0]      w_wr_addr, w_rd_addr;
   logic [ACC_WIDTH-1:0]  w_rd_data, w_acc_sum;
   logic [DATA_WIDTH-1:0] w_a_data;
   logic                  w_pop, w_pop_last, w_o_take, w_issue_ok;
   logic [1:0]            w_occupancy;

   csi_acc_ram #(
      .DEPTH  (NUM_SC),
      .WIDTH  (ACC_WIDTH),
      .ADDR_W (IDX_W)
   ) u_acc_ram (
      .clk_in    (clk_in),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (w_acc_sum),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   // The RAM output already holds acc[sc_idx]: every accepted sample
   // pre-reads the entry the next sample will update.
   assign w_acc_sum = (w_clr ? '0 : w_rd_data) + ACC_WIDTH'(mag_in);

`ifdef CSI_AVG_ROUND_EN
   localparam int RND_W = ACC_WIDTH + 1;
   logic [RND_W-1:0] w_rounded;
   assign w_rounded = {1'b0, w_rd_data} + (RND_W'(1) << (LOG2_AVG - 1));
   assign w_a_data  = DATA_WIDTH'(w_rounded >> LOG2_AVG);
`else
   assign w_a_data  = DATA_WIDTH'(w_rd_data >> LOG2_AVG);
`endif

   assign w_pop       = r_o_valid && avg_ready_in;
   assign w_pop_last  = w_pop && (r_o_idx == LAST_IDX);
   assign w_o_take    = !r_o_valid || w_pop;
   // A new read may issue only if its data is guaranteed a slot next cycle.
   assign w_occupancy = 2'(r_o_valid) + 2'(r_s_valid) + 2'(r_a_valid) - 2'(w_pop);
   assign w_issue_ok  = (w_occupancy <= 2'd1);

   always_comb begin
      w_state_next      = r_state;
      w_sc_idx_next     = r_sc_idx;
      w_frame_next      = r_frame_cnt;
      w_drop            = 1'b0;
      w_wr_en           = 1'b0;
      w_clr             = 1'b0;
      w_wr_addr         = r_sc_idx;
      w_rd_en           = 1'b0;
      w_rd_addr         = r_rd_ptr;
      w_a_issue         = 1'b0;
      w_rd_ptr_next     = r_rd_ptr;
      w_issue_done_next = r_issue_done;
      unique case (r_state)
         ST_IDLE: begin
            if (mag_valid_in) begin
               if (sof_in) begin
                  w_wr_en       = 1'b1;
                  w_clr         = 1'b1;
                  w_wr_addr     = '0;
                  w_rd_en       = 1'b1;
                  w_rd_addr     = IDX_W'(1);
                  w_sc_idx_next = IDX_W'(1);
                  w_frame_next  = '0;
                  w_state_next  = ST_ACCUM;
               end else begin
                  w_drop = 1'b1;
               end
            end
         end
         ST_ACCUM: begin
            if (mag_valid_in) begin
               if (sof_in && (r_sc_idx != '0)) begin
                  // Misaligned frame start: restart the window here.
                  w_wr_en       = 1'b1;
                  w_clr         = 1'b1;
                  w_wr_addr     = '0;
                  w_rd_en       = 1'b1;
                  w_rd_addr     = IDX_W'(1);
                  w_sc_idx_next = IDX_W'(1);
                  w_frame_next  = '0;
               end else if (!sof_in && (r_sc_idx == '0)) begin
                  w_drop = 1'b1;
               end else begin
                  w_wr_en = 1'b1;
                  w_clr   = (r_frame_cnt == '0);
                  w_rd_en = 1'b1;
                  if (r_sc_idx == LAST_IDX) begin
                     // Pre-read of index 0 doubles as the first drain read.
                     w_rd_addr     = '0;
                     w_sc_idx_next = '0;
                     if (r_frame_cnt == FRAME_MAX) begin
                        w_state_next      = ST_DRAIN;
                        w_a_issue         = 1'b1;
                        w_rd_ptr_next     = IDX_W'(1);
                        w_issue_done_next = 1'b0;
                     end else begin
                        w_frame_next = r_frame_cnt + LOG2_AVG'(1);
                     end
                  end else begin
                     w_rd_addr     = r_sc_idx + IDX_W'(1);
                     w_sc_idx_next = r_sc_idx + IDX_W'(1);
                  end
               end
            end
         end
         ST_DRAIN: begin
            w_drop = mag_valid_in;
            if (!r_issue_done && w_issue_ok) begin
               w_rd_en       = 1'b1;
               w_rd_addr     = r_rd_ptr;
               w_a_issue     = 1'b1;
               w_rd_ptr_next = r_rd_ptr + IDX_W'(1);
               if (r_rd_ptr == LAST_IDX) begin
                  w_issue_done_next = 1'b1;
               end
            end
            if (w_pop_last) begin
               w_state_next  = ST_IDLE;
               w_sc_idx_next = '0;
               w_frame_next  = '0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state      <= ST_IDLE;
         r_sc_idx     <= '0;
         r_frame_cnt  <= '0;
         r_drop       <= 1'b0;
         r_rd_ptr     <= '0;
         r_issue_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_sc_idx     <= w_sc_idx_next;
         r_frame_cnt  <= w_frame_next;
         r_drop       <= w_drop;
         r_rd_ptr     <= w_rd_ptr_next;
         r_issue_done <= w_issue_done_next;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_a_valid <= 1'b0;
         r_a_idx   <= '0;
         r_o_valid <= 1'b0;
         r_o_data  <= '0;
         r_o_idx   <= '0;
         r_s_valid <= 1'b0;
         r_s_data  <= '0;
         r_s_idx   <= '0;
      end else begin
         r_a_valid <= w_a_issue;
         if (w_a_issue) begin
            r_a_idx <= w_rd_addr;
         end
         // Output slot refills from skid first to keep beats in order.
         if (w_o_take) begin
            if (r_s_valid) begin
               r_o_valid <= 1'b1;
               r_o_data  <= r_s_data;
               r_o_idx   <= r_s_idx;
            end else if (r_a_valid) begin
               r_o_valid <= 1'b1;
               r_o_data  <= w_a_data;
               r_o_idx   <= r_a_idx;
            end else begin
               r_o_valid <= 1'b0;
            end
         end
         if (r_s_valid) begin
            if (w_o_take) begin
               r_s_valid <= r_a_valid;
               r_s_data  <= w_a_data;
               r_s_idx   <= r_a_idx;
            end
         end else if (r_a_valid && !w_o_take) begin
            r_s_valid <= 1'b1;
            r_s_data  <= w_a_data;
            r_s_idx   <= r_a_idx;
         end
      end
   end

   assign avg_out       = r_o_data;
   assign avg_index_out = r_o_idx;
   assign avg_valid_out = r_o_valid;
   assign avg_last_out  = r_o_valid && (r_o_idx == LAST_IDX);
   assign busy_out      = (r_state != ST_IDLE);
   assign drop_out      = r_drop;

endmodule
